mem_controller: RTL and testbench

//  Memory controller driven by core_control's 3-bit data-condition code. Code 100 (store) captures an

---
 rtl/mem_controller.sv | 104 ++++++++++
 tb/tb_mem_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// mem_controller: captures an input burst into word memory and streams it out in REG_WORDS-sized chunks into a register bank
module mem_controller #(
  parameter int DW        = 8,
  parameter int DEPTH     = 64,
  parameter int REG_WORDS = 4
) (
  input  logic                    mc_clk,
  input  logic                    mc_reset_n,
  input  logic [2:0]              mc_data_contition,
  input  logic [5:0]              mc_data_length,
  input  logic [DW-1:0]           mc_data_in,
  input  logic                    mc_data_in_valid,
  output logic                    mc_data_in_ready,
  output logic                    mc_done,
  output logic                    mc_data_done,
  output logic [REG_WORDS*DW-1:0] mc_reg_data,
  output logic [5:0]              mc_reg_count,
  output logic                    mc_reg_valid
);
  localparam logic [2:0] S_IDLE = 3'd0, S_STORE = 3'd1, S_WAIT = 3'd2, S_TRANS = 3'd3, S_HOLD = 3'd4;
  localparam int JW = REG_WORDS > 1 ? $clog2(REG_WORDS) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(REG_WORDS - 1);
  logic [2:0]    r_state;
  logic [5:0]    r_len, r_wr_ptr, r_rd_ptr;
  logic [JW-1:0] r_j;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_reg [REG_WORDS];
  logic w_st, w_tr, w_idle, w_acc, w_store_end, w_empty, w_rd_last;
  assign w_st             = mc_data_contition == 3'b100;
  assign w_tr             = mc_data_contition == 3'b010;
  assign w_idle           = !w_st && !w_tr && mc_data_contition != 3'b001;
  assign mc_data_in_ready = r_state == S_STORE && r_wr_ptr < r_len;
  assign w_acc            = mc_data_in_ready && mc_data_in_valid;
  assign w_store_end      = r_wr_ptr == r_len || (w_acc && r_wr_ptr + 6'd1 == r_len);
  assign w_empty          = r_rd_ptr == r_len;
  assign w_rd_last        = r_rd_ptr + 6'd1 == r_len;
  for (genvar i = 0; i < REG_WORDS; i++) begin : g_pack
    assign mc_reg_data[i*DW +: DW] = r_reg[i];
  end
  always_ff @(posedge mc_clk) begin
    if (w_acc) r_mem[r_wr_ptr] <= mc_data_in;
  end
  always_ff @(posedge mc_clk or negedge mc_reset_n) begin
    if (!mc_reset_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_j          <= '0;
      mc_done      <= 1'b0;
      mc_data_done <= 1'b0;
      mc_reg_count <= '0;
      mc_reg_valid <= 1'b0;
      for (int i = 0; i < REG_WORDS; i++) r_reg[i] <= '0;
    end else begin
      mc_done <= 1'b0;
      if (w_st && (r_state == S_IDLE || r_state == S_HOLD || r_state == S_TRANS)) begin
        r_state      <= S_STORE;
        r_len        <= mc_data_length;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        mc_data_done <= 1'b0;
        mc_reg_valid <= 1'b0;
        mc_reg_count <= '0;
      end else if (w_idle) begin
        r_state      <= S_IDLE;
        mc_reg_valid <= 1'b0;
        mc_reg_count <= '0;
        mc_data_done <= 1'b0;
      end else if (r_state == S_STORE) begin
        if (w_acc) r_wr_ptr <= r_wr_ptr + 6'd1;
        if (w_store_end) begin
          mc_done <= 1'b1;
          r_state <= S_WAIT;
        end
      end else if (w_tr && (r_state == S_WAIT || r_state == S_HOLD)) begin
        // bank is cleared on entry so words beyond a short chunk read back as zero
        r_state      <= S_TRANS;
        r_j          <= '0;
        mc_reg_valid <= 1'b0;
        for (int i = 0; i < REG_WORDS; i++) r_reg[i] <= '0;
      end else if (r_state == S_TRANS) begin
        if (w_empty) begin
          mc_done      <= 1'b1;
          mc_reg_count <= '0;
          mc_reg_valid <= 1'b1;
          mc_data_done <= 1'b1;
          r_state      <= S_HOLD;
        end else begin
          r_reg[r_j] <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + 6'd1;
          r_j        <= r_j + 1'b1;
          if (r_j == J_LAST || w_rd_last) begin
            mc_done      <= 1'b1;
            mc_reg_valid <= 1'b1;
            mc_reg_count <= 6'(r_j) + 6'd1;
            mc_data_done <= w_rd_last;
            r_state      <= S_HOLD;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed scoreboard bench for mem_controller store/transfer/abort/reset behaviour
module tb_mem_controller;
  localparam int DW = 8;
  localparam int RW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] code = 3'b000;
  logic [5:0] len_in = '0;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic ready, done, data_done, reg_valid;
  logic [RW*DW-1:0] reg_data;
  logic [5:0] reg_count;
  int n_tests = 0;
  int n_fail = 0;
  int len_model = 0;
  int rd_model = 0;
  logic [DW-1:0] sb[$];
  mem_controller #(.DW(DW), .DEPTH(64), .REG_WORDS(RW)) dut (
    .mc_clk(clk),
    .mc_reset_n(rst_n),
    .mc_data_contition(code),
    .mc_data_length(len_in),
    .mc_data_in(din),
    .mc_data_in_valid(din_valid),
    .mc_data_in_ready(ready),
    .mc_done(done),
    .mc_data_done(data_done),
    .mc_reg_data(reg_data),
    .mc_reg_count(reg_count),
    .mc_reg_valid(reg_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_data_done"}, 64'(data_done), 64'd0);
    chk({tag, "_reg_data"}, 64'(reg_data), 64'd0);
    chk({tag, "_reg_count"}, 64'(reg_count), 64'd0);
    chk({tag, "_reg_valid"}, 64'(reg_valid), 64'd0);
  endtask
  task automatic do_store(input int len, input logic [15:0] vpat, input logic [7:0] base);
    int cnt;
    int cyc;
    bit fin;
    cnt = 0;
    cyc = 0;
    fin = 1'b0;
    code = 3'b100;
    len_in = 6'(len);
    tick();
    chk("store_entry_done", 64'(done), 64'd0);
    len_model = len;
    rd_model = 0;
    while (!fin && cyc < 64) begin
      logic v;
      logic acc;
      v = (cyc < 16) ? vpat[cyc] : 1'b1;
      din = v ? base + 8'(cnt) : 8'hEE;
      din_valid = v;
      chk("store_ready", 64'(ready), 64'(cnt < len));
      acc = v && (cnt < len);
      if (acc) begin
        sb.push_back(din);
        cnt++;
      end
      tick();
      fin = (len == 0 && cyc == 0) || (acc && cnt == len);
      chk("store_done", 64'(done), 64'(fin));
      cyc++;
    end
    din_valid = 1'b0;
    code = 3'b001;
    chk("store_ready_after", 64'(ready), 64'd0);
    tick();
    chk("store_done_single", 64'(done), 64'd0);
  endtask
  task automatic do_transfer(input int exp_dd);
    int k;
    int lat;
    logic [RW*DW-1:0] exp_bank;
    exp_bank = '0;
    k = (len_model - rd_model < RW) ? len_model - rd_model : RW;
    lat = (k == 0) ? 1 : k;
    for (int j = 0; j < k; j++) exp_bank[j*DW +: DW] = sb.pop_front();
    code = 3'b010;
    tick();
    chk("trans_entry_valid", 64'(reg_valid), 64'd0);
    chk("trans_entry_done", 64'(done), 64'd0);
    for (int c = 1; c <= lat; c++) begin
      tick();
      chk("trans_done", 64'(done), 64'(c == lat));
    end
    code = 3'b001;
    chk("bank_data", 64'(reg_data), 64'(exp_bank));
    chk("bank_count", 64'(reg_count), 64'(k));
    chk("bank_valid", 64'(reg_valid), 64'd1);
    chk("bank_data_done", 64'(data_done), 64'(exp_dd));
    rd_model += k;
    tick();
    chk("hold_done_low", 64'(done), 64'd0);
    chk("hold_data_stable", 64'(reg_data), 64'(exp_bank));
  endtask
  initial begin
    tick();
    tick();
    chk_cleared("reset");
    #4 rst_n = 1'b1;
    tick();
    chk_cleared("idle");
    do_store(5, 16'hFFFF, 8'hA0);
    do_transfer(0);
    do_transfer(1);
    do_store(10, 16'hFFFF, 8'h10);
    do_transfer(0);
    do_transfer(0);
    do_transfer(1);
    chk("third_bank_explicit", 64'(reg_data), 64'h0000_1918);
    do_store(3, 16'h0019, 8'hC0);
    do_transfer(1);
    do_store(0, 16'hFFFF, 8'hD0);
    do_transfer(1);
    code = 3'b100;
    len_in = 6'd6;
    tick();
    for (int i = 0; i < 2; i++) begin
      din = 8'h60 + 8'(i);
      din_valid = 1'b1;
      chk("abort_ready_pre", 64'(ready), 64'd1);
      tick();
      chk("abort_done_pre", 64'(done), 64'd0);
    end
    code = 3'b000;
    din_valid = 1'b0;
    tick();
    chk_cleared("abort");
    code = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle_ready", 64'(ready), 64'd0);
      chk("abort_idle_done", 64'(done), 64'd0);
    end
    sb.delete();
    do_store(2, 16'hFFFF, 8'h70);
    do_transfer(1);
    do_store(10, 16'hFFFF, 8'h30);
    do_transfer(0);
    code = 3'b010;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_cleared("async_reset");
    code = 3'b000;
    #2 rst_n = 1'b1;
    tick();
    chk_cleared("post_reset");
    sb.delete();
    do_store(3, 16'hFFFF, 8'h50);
    do_transfer(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
